serial_frame_tx: RTL and testbench

- Upstream stage of the 32-bit capture shift register: drives that register's 1-bit serial input.
- Accepts parallel words on a valid/ready handshake and buffers one word.
- Emits each word as a framed serial stream, one bit per clk: start bit, data MSB-first, optional parity, idle gap.
- Framing lets the capture register's parallel tap be aligned and decoded downstream.

---
 rtl/serial_frame_pkg.sv | 21 ++
 rtl/serial_frame_hold.sv | 30 +++
 rtl/serial_frame_tx.sv | 130 +++++++++++++
 tb/tb_serial_frame_tx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the framed serial transmitter.
// Parity support is selected by the SERIAL_FRAME_TX_PARITY_EN macro.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam logic START_BIT = 1'b1;
    localparam logic IDLE_BIT  = 1'b0;

    // Bits that carry frame_active: start + data + optional parity.
    function automatic int frame_len(input int data_w, input bit parity_en);
        return 1 + data_w + (parity_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/serial_frame_hold.sv
// One-entry valid/ready holding register feeding the frame shifter.
module serial_frame_hold #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         load,
    output logic [W-1:0] hold_q,
    output logic         hold_vld
);

    // Accept needs an empty register and load needs a full one, so they never overlap.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q   <= '0;
            hold_vld <= 1'b0;
        end else if (in_valid && !hold_vld) begin
            hold_q   <= in_data;
            hold_vld <= 1'b1;
        end else if (load) begin
            hold_vld <= 1'b0;
        end
    end

    assign in_ready = !hold_vld;

endmodule

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit, data MSB-first, optional even parity
// (SERIAL_FRAME_TX_PARITY_EN), then GAP_CYCLES idle zeros.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_out,
    output logic              frame_active,
    output logic              busy
);

    state_t            state, state_d;
    logic [DATA_W-1:0] shifter, shifter_d;
    logic [3:0]        bit_cnt, bit_cnt_d;
    logic [DATA_W-1:0] hold_q;
    logic              hold_vld;
    logic              load;
    logic              ser_d, active_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    serial_frame_hold #(.W(DATA_W)) u_hold (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .load     (load),
        .hold_q   (hold_q),
        .hold_vld (hold_vld)
    );

    // Outputs are registered from the current state, so ser_out trails state by one cycle.
    always_comb begin
        state_d   = state;
        shifter_d = shifter;
        bit_cnt_d = bit_cnt;
        load      = 1'b0;
        ser_d     = IDLE_BIT;
        active_d  = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state)
            ST_IDLE: begin
                if (hold_vld) load = 1'b1;
            end
            ST_START: begin
                ser_d     = START_BIT;
                active_d  = 1'b1;
                state_d   = ST_DATA;
                bit_cnt_d = 4'(DATA_W - 1);
            end
            ST_DATA: begin
                ser_d     = shifter[DATA_W-1];
                active_d  = 1'b1;
                shifter_d = {shifter[DATA_W-2:0], 1'b0};
                if (bit_cnt == 4'd0) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    state_d   = ST_PAR;
`else
                    state_d   = ST_GAP;
                    bit_cnt_d = 4'(GAP_CYCLES - 1);
`endif
                end else begin
                    bit_cnt_d = bit_cnt - 4'd1;
                end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            ST_PAR: begin
                ser_d     = par_q;
                active_d  = 1'b1;
                state_d   = ST_GAP;
                bit_cnt_d = 4'(GAP_CYCLES - 1);
            end
`endif
            ST_GAP: begin
                if (bit_cnt == 4'd0) begin
                    if (hold_vld) load = 1'b1;
                    else          state_d = ST_IDLE;
                end else begin
                    bit_cnt_d = bit_cnt - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Loading from IDLE or the last gap cycle both jump straight to START.
        if (load) begin
            shifter_d = hold_q;
            state_d   = ST_START;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            par_d     = ^hold_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            shifter      <= '0;
            bit_cnt      <= '0;
            ser_out      <= IDLE_BIT;
            frame_active <= 1'b0;
            busy         <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state        <= state_d;
            shifter      <= shifter_d;
            bit_cnt      <= bit_cnt_d;
            ser_out      <= ser_d;
            frame_active <= active_d;
            busy         <= (state != ST_IDLE) || hold_vld;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            par_q        <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: frame-schedule reference model checked every cycle.
module tb_serial_frame_tx;

`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int FL = 10;
`else
    localparam int FL = 9;
`endif
    localparam int GAP = 2;
    localparam int PER = FL + GAP;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready, ser_out, frame_active, busy;

    serial_frame_tx #(.DATA_W(8), .GAP_CYCLES(GAP)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ser_out      (ser_out),
        .frame_active (frame_active),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Each accepted word: accept edge n, load edge l, payload d.
    typedef struct { int n; int l; logic [7:0] d; } frm_t;
    frm_t q[$];

    int   cyc = 0;
    int   passed = 0;
    int   fails = 0;
    int   total = 0;
    logic m_ready = 1'b1;
    logic last_acc = 1'b0;

    function automatic logic frame_bit(input logic [7:0] d, input int j);
        if (j == 0) return 1'b1;
        if (j <= 8) return d[8-j];
        return ^d;
    endfunction

    // Start bit is visible after edge l+1, the rest follow one per edge.
    function automatic logic exp_ser(input int e);
        foreach (q[i]) if (e - q[i].l - 1 >= 0 && e - q[i].l - 1 < FL) return frame_bit(q[i].d, e - q[i].l - 1);
        return 1'b0;
    endfunction

    function automatic logic exp_act(input int e);
        foreach (q[i]) if (e - q[i].l - 1 >= 0 && e - q[i].l - 1 < FL) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_ready(input int e);
        foreach (q[i]) if (q[i].n <= e && e < q[i].l) return 1'b0;
        return 1'b1;
    endfunction

    // busy reflects "frame in progress or word held" as of the previous edge.
    function automatic logic exp_busy(input int e);
        int x;
        x = e - 1;
        foreach (q[i]) begin
            if (q[i].l <= x && x <= q[i].l + PER - 1) return 1'b1;
            if (q[i].n <= x && x < q[i].l) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h want %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        logic acc;
        int   lnew;
        acc = !rst && in_valid && m_ready;
        @(posedge clk);
        cyc++;
        last_acc = acc;
        if (rst) begin
            q.delete();
        end else if (acc) begin
            lnew = cyc + 1;
            if (q.size() > 0 && q[$].l + PER > lnew) lnew = q[$].l + PER;
            q.push_back('{n: cyc, l: lnew, d: in_data});
        end
        #1;
        chk("ser_out", 32'(ser_out), 32'(exp_ser(cyc)));
        chk("frame_active", 32'(frame_active), 32'(exp_act(cyc)));
        chk("busy", 32'(busy), 32'(exp_busy(cyc)));
        chk("in_ready", 32'(in_ready), 32'(exp_ready(cyc)));
        m_ready = exp_ready(cyc);
        while (q.size() > 1 && q[0].l + PER + 2 < cyc) void'(q.pop_front());
    endtask

    task automatic send(input logic [7:0] d);
        int k;
        k = 0;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            tick();
            k++;
        end while (!last_acc && k < 100);
        if (!last_acc) begin
            total++;
            fails++;
            $error("FAIL send_timeout: got no accept want accept of %0h", d);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int         n0, l1, act_cnt;
        logic [10:0] seq;

        // Reset held 3 cycles, then idle.
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (10) tick();

        // Single word 0xA5 with explicit waveform capture.
        send(8'hA5);
        n0 = cyc;
        seq = '0;
        act_cnt = 0;
        repeat (14) begin
            tick();
            if (cyc >= n0 + 2 && cyc <= n0 + 12) seq = {seq[9:0], ser_out};
            if (frame_active) act_cnt++;
        end
        chk("a5_bits", 32'(seq), 32'(11'b11010010100));
        chk("a5_active_len", 32'(act_cnt), 32'(FL));
        repeat (4) tick();

        // Back-to-back words with in_valid held.
        in_valid = 1'b1;
        send(8'h81);
        send(8'h7E);
        repeat (2 * PER + 4) tick();

        // Parity-relevant payloads.
        send(8'h07);
        send(8'h03);
        repeat (2 * PER + 4) tick();

        // Stall: a pulse while the holding register is full must not be taken.
        send(8'h11);
        send(8'h22);
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        chk("stall_ready", 32'(in_ready), 32'(0));
        in_valid = 1'b0;
        repeat (3) tick();
        send(8'h55);
        repeat (3 * PER + 4) tick();

        // Reset during the 4th data bit with a second word held.
        send(8'h3C);
        l1 = q[$].l;
        send(8'h99);
        while (cyc < l1 + 5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_ser_out", 32'(ser_out), 32'(0));
        chk("rst_active", 32'(frame_active), 32'(0));
        chk("rst_ready", 32'(in_ready), 32'(1));
        repeat (2 * PER) tick();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 79) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = 8'($urandom);
            tick();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (2 * PER) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
